// File: rtl/xbus_sram_ctl.sv
// xbus_sram_ctl: bridges a 32-bit xbus word request onto a 16-bit async SRAM.
// Each word is two halfword accesses (LO then HI) of WAIT+1 cycles each.
// All SRAM pins and handshake pulses come straight from flops.
module xbus_sram_ctl #(
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [21:0] sdram_addr,
    input  logic [31:0] sdram_data_out,
    input  logic        sdram_req,
    input  logic        sdram_write,
    output logic [31:0] sdram_data_in,
    output logic        sdram_ready,
    output logic        sdram_done,
    output logic [22:0] sram_a,
    input  logic [15:0] sram_d_in,
    output logic [15:0] sram_d_out,
    output logic        sram_d_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR_LO, WR_HI, ACK, HOLD} state_t;

    localparam logic [3:0] WLAST = 4'(WAIT);

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [21:0] addr_r, addr_nx;
    logic [31:0] data_r, data_nx;
    logic        is_wr, is_wr_nx;
    logic [31:0] rdata_nx;
    logic [22:0] sram_a_nx;
    logic [15:0] sram_d_out_nx;
    logic        ready_nx, done_nx, d_oe_nx, ce_n_nx, oe_n_nx, we_n_nx;
    logic        last, nx_rd, nx_wr;

    // State, latched transaction and every output pin are registered together
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_r        <= '0;
            data_r        <= '0;
            is_wr         <= 1'b0;
            sdram_data_in <= '0;
            sdram_ready   <= 1'b0;
            sdram_done    <= 1'b0;
            sram_a        <= '0;
            sram_d_out    <= '0;
            sram_d_oe     <= 1'b0;
            sram_ce_n     <= 1'b1;
            sram_oe_n     <= 1'b1;
            sram_we_n     <= 1'b1;
        end else begin
            state         <= state_nx;
            cnt           <= cnt_nx;
            addr_r        <= addr_nx;
            data_r        <= data_nx;
            is_wr         <= is_wr_nx;
            sdram_data_in <= rdata_nx;
            sdram_ready   <= ready_nx;
            sdram_done    <= done_nx;
            sram_a        <= sram_a_nx;
            sram_d_out    <= sram_d_out_nx;
            sram_d_oe     <= d_oe_nx;
            sram_ce_n     <= ce_n_nx;
            sram_oe_n     <= oe_n_nx;
            sram_we_n     <= we_n_nx;
        end
    end

    // Next state plus next values of the registered pins, derived from state_nx
    always_comb begin
        state_nx      = state;
        cnt_nx        = '0;
        addr_nx       = addr_r;
        data_nx       = data_r;
        is_wr_nx      = is_wr;
        rdata_nx      = sdram_data_in;
        sram_a_nx     = sram_a;
        sram_d_out_nx = sram_d_out;
        last          = (cnt == WLAST);

        case (state)
            IDLE: begin
                // Write wins when both requests are up
                if (sdram_write) begin
                    addr_nx  = sdram_addr;
                    data_nx  = sdram_data_out;
                    is_wr_nx = 1'b1;
                    state_nx = WR_LO;
                end else if (sdram_req) begin
                    addr_nx  = sdram_addr;
                    is_wr_nx = 1'b0;
                    state_nx = RD_LO;
                end
            end
            RD_LO: begin
                if (last) begin
                    rdata_nx[15:0] = sram_d_in;
                    state_nx       = RD_HI;
                end else cnt_nx = cnt + 4'd1;
            end
            RD_HI: begin
                if (last) begin
                    rdata_nx[31:16] = sram_d_in;
                    state_nx        = ACK;
                end else cnt_nx = cnt + 4'd1;
            end
            WR_LO: begin
                if (last) state_nx = WR_HI;
                else      cnt_nx   = cnt + 4'd1;
            end
            WR_HI: begin
                if (last) state_nx = ACK;
                else      cnt_nx   = cnt + 4'd1;
            end
            ACK:  state_nx = HOLD;
            // Wait for both levels to drop so a held request cannot retrigger
            HOLD: if (!sdram_req && !sdram_write) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        nx_rd   = (state_nx == RD_LO) || (state_nx == RD_HI);
        nx_wr   = (state_nx == WR_LO) || (state_nx == WR_HI);
        ce_n_nx = !(nx_rd || nx_wr);
        oe_n_nx = !nx_rd;
        d_oe_nx = nx_wr;
        // First cycle of each write half keeps we_n high for address setup
        we_n_nx = !(nx_wr && (cnt_nx != 4'd0));

        if (nx_rd || nx_wr)
            sram_a_nx = {addr_nx, (state_nx == RD_HI) || (state_nx == WR_HI)};
        if (state_nx == WR_LO) sram_d_out_nx = data_nx[15:0];
        if (state_nx == WR_HI) sram_d_out_nx = data_nx[31:16];

        ready_nx = (state_nx == ACK) && !is_wr_nx;
        done_nx  = (state_nx == ACK) &&  is_wr_nx;
    end

endmodule
